// File: rtl/dial_readback.sv
// dial_readback: decodes the stepper phase bus into an absolute dial position
// and reports the settled character as ASCII over a valid/ack handshake.
module dial_readback #(
    parameter int STEPS_PER_POS = 4,
    parameter int SETTLE        = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [3:0] motor_drv,
    input  logic       ack,
    output logic [4:0] pos,
    output logic [6:0] ascii_out,
    output logic       valid,
    output logic       busy,
    output logic       dir_err,
    output logic       misalign,
    output logic       overrun
);
    localparam int SW = $clog2(STEPS_PER_POS);
    localparam int IW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SUB_MAX = SW'(STEPS_PER_POS - 1);

    logic [3:0]    drv_q, last_ph_q, last_ph_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [4:0]    pos_q, pos_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [6:0]    ascii_q, ascii_d;
    logic          moved_q, moved_d, valid_q, valid_d;
    logic          dir_err_q, dir_err_d, misalign_q, misalign_d, overrun_q, overrun_d;
    logic          nz, fwd, rev, rpt;

    function automatic logic [6:0] to_ascii(input logic [4:0] p);
        return (p >= 5'd1 && p <= 5'd26) ? 7'h60 + 7'(p) :
               p == 5'd29 ? 7'h2C : p == 5'd30 ? 7'h2E : p == 5'd31 ? 7'h3F : 7'h20;
    endfunction

    always_comb begin
        nz         = drv_q != 4'b0000;
        fwd        = nz && drv_q == {last_ph_q[2:0], last_ph_q[3]};
        rev        = nz && drv_q == {last_ph_q[0], last_ph_q[3:1]};
        rpt        = !nz && moved_q && idle_q == IW'(SETTLE - 1);
        last_ph_d  = (fwd || rev) ? drv_q : last_ph_q;
        moved_d    = moved_q || fwd || rev;
        sub_d      = fwd ? (sub_q == SUB_MAX ? '0 : sub_q + SW'(1)) :
                     rev ? (sub_q == '0 ? SUB_MAX : sub_q - SW'(1)) : sub_q;
        pos_d      = (fwd && sub_q == SUB_MAX) ? pos_q + 5'd1 :
                     (rev && sub_q == '0) ? pos_q - 5'd1 : pos_q;
        dir_err_d  = dir_err_q || (nz && drv_q != last_ph_q && !fwd && !rev);
        idle_d     = nz ? '0 : (moved_q && idle_q != IW'(SETTLE)) ? idle_q + IW'(1) : idle_q;
        valid_d    = valid_q && !ack;
        ascii_d    = ascii_q;
        misalign_d = misalign_q;
        overrun_d  = overrun_q;
        // An ack on the report edge frees the slot, so the new character loads without overrun
        if (rpt) begin
            moved_d = 1'b0;
            if (sub_q != '0) misalign_d = 1'b1;
            else if (!valid_q || ack) begin
                ascii_d = to_ascii(pos_q);
                valid_d = 1'b1;
            end else overrun_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            drv_q      <= 4'b0000;
            last_ph_q  <= 4'b0001;
            sub_q      <= '0;
            pos_q      <= 5'd0;
            idle_q     <= '0;
            moved_q    <= 1'b0;
            ascii_q    <= 7'h20;
            valid_q    <= 1'b0;
            dir_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            drv_q      <= motor_drv;
            last_ph_q  <= last_ph_d;
            sub_q      <= sub_d;
            pos_q      <= pos_d;
            idle_q     <= idle_d;
            moved_q    <= moved_d;
            ascii_q    <= ascii_d;
            valid_q    <= valid_d;
            dir_err_q  <= dir_err_d;
            misalign_q <= misalign_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pos       = pos_q;
    assign ascii_out = ascii_q;
    assign valid     = valid_q;
    assign busy      = moved_q || drv_q != 4'b0000;
    assign dir_err   = dir_err_q;
    assign misalign  = misalign_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_dial_readback.sv
// tb_dial_readback: directed tests of dial_readback with hand-computed expectations.
module tb_dial_readback;
    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] motor_drv = 4'b0001;
    logic       ack = 1'b0;
    logic [4:0] pos;
    logic [6:0] ascii_out;
    logic       valid, busy, dir_err, misalign, overrun;
    int checks = 0;
    int errors = 0;

    dial_readback #(.STEPS_PER_POS(4), .SETTLE(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .motor_drv(motor_drv), .ack(ack),
        .pos(pos), .ascii_out(ascii_out), .valid(valid), .busy(busy),
        .dir_err(dir_err), .misalign(misalign), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic drive(input logic [3:0] ph, input int n);
        motor_drv = ph;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic full_fwd();
        drive(4'b0010, 2); drive(4'b0100, 2); drive(4'b1000, 2); drive(4'b0001, 2);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge sys_clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        motor_drv = 4'b0001;
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (pos !== 5'd0 || valid !== 1'b0 || busy !== 1'b0 || ascii_out !== 7'h20) begin errors++; $display("FAIL rst_outputs got pos=%0d valid=%b busy=%b ascii=%h exp 0 0 0 20", pos, valid, busy, ascii_out); end
        checks++; if ({dir_err, misalign, overrun} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {dir_err, misalign, overrun}); end
        reset = 1'b1;
        repeat (4) @(negedge sys_clk);
        checks++; if (pos !== 5'd0 || dir_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_hold_p0 got pos=%0d dir_err=%b busy=%b exp 0 0 1", pos, dir_err, busy); end
        drive(4'b0000, 12);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_report got valid=%b busy=%b exp 0 0", valid, busy); end
    endtask

    task automatic test_forward();
        repeat (4) begin
            drive(4'b0010, 3); drive(4'b0100, 3); drive(4'b1000, 3); drive(4'b0001, 3);
        end
        checks++; if (pos !== 5'd4 || busy !== 1'b1) begin errors++; $display("FAIL fwd_pos got pos=%0d busy=%b exp 4 1", pos, busy); end
        drive(4'b0000, 8);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fwd_early_valid got %b exp 0", valid); end
        @(negedge sys_clk);
        checks++; if (valid !== 1'b1 || ascii_out !== 7'h64) begin errors++; $display("FAIL fwd_report got valid=%b ascii=%h exp 1 64", valid, ascii_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fwd_busy got %b exp 0", busy); end
        ack_pulse();
        checks++; if (valid !== 1'b0 || ascii_out !== 7'h64) begin errors++; $display("FAIL fwd_ack got valid=%b ascii=%h exp 0 64", valid, ascii_out); end
    endtask

    task automatic test_reverse_wrap();
        reset = 1'b0;
        motor_drv = 4'b0000;
        @(negedge sys_clk);
        reset = 1'b1;
        drive(4'b1000, 2);
        checks++; if (pos !== 5'd31) begin errors++; $display("FAIL rev_wrap_pos got %0d exp 31", pos); end
        drive(4'b0100, 2); drive(4'b0010, 2); drive(4'b0001, 2); drive(4'b0000, 10);
        checks++; if (pos !== 5'd31 || valid !== 1'b1 || ascii_out !== 7'h3F || misalign !== 1'b0) begin errors++; $display("FAIL rev_report got pos=%0d valid=%b ascii=%h misalign=%b exp 31 1 3f 0", pos, valid, ascii_out, misalign); end
        ack_pulse();
    endtask

    task automatic test_illegal();
        drive(4'b0100, 2);
        checks++; if (dir_err !== 1'b1 || pos !== 5'd31) begin errors++; $display("FAIL illegal got dir_err=%b pos=%0d exp 1 31", dir_err, pos); end
        full_fwd();
        checks++; if (pos !== 5'd0) begin errors++; $display("FAIL illegal_recover_pos got %0d exp 0", pos); end
        drive(4'b0000, 10);
        checks++; if (valid !== 1'b1 || ascii_out !== 7'h20 || misalign !== 1'b0) begin errors++; $display("FAIL illegal_report got valid=%b ascii=%h misalign=%b exp 1 20 0", valid, ascii_out, misalign); end
        ack_pulse();
    endtask

    task automatic test_misalign_overrun();
        drive(4'b0010, 2); drive(4'b0100, 2); drive(4'b0000, 10);
        checks++; if (misalign !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL misalign got misalign=%b valid=%b exp 1 0", misalign, valid); end
        drive(4'b1000, 2); drive(4'b0001, 2); drive(4'b0000, 10);
        checks++; if (valid !== 1'b1 || ascii_out !== 7'h61 || overrun !== 1'b0) begin errors++; $display("FAIL first_char got valid=%b ascii=%h overrun=%b exp 1 61 0", valid, ascii_out, overrun); end
        full_fwd();
        drive(4'b0000, 10);
        checks++; if (overrun !== 1'b1 || valid !== 1'b1 || ascii_out !== 7'h61 || pos !== 5'd2) begin errors++; $display("FAIL overrun got overrun=%b valid=%b ascii=%h pos=%0d exp 1 1 61 2", overrun, valid, ascii_out, pos); end
    endtask

    task automatic test_reset_mid_move();
        drive(4'b0010, 2);
        drive(4'b0100, 1);
        reset = 1'b0;
        #1;
        checks++; if (pos !== 5'd0 || ascii_out !== 7'h20 || valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs got pos=%0d ascii=%h valid=%b busy=%b exp 0 20 0 0", pos, ascii_out, valid, busy); end
        checks++; if ({dir_err, misalign, overrun} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b exp 000", {dir_err, misalign, overrun}); end
        @(negedge sys_clk);
        reset = 1'b1;
        drive(4'b0010, 2);
        checks++; if (dir_err !== 1'b0 || pos !== 5'd0) begin errors++; $display("FAIL mid_rst_step got dir_err=%b pos=%0d exp 0 0", dir_err, pos); end
        drive(4'b0100, 2); drive(4'b1000, 2); drive(4'b0001, 2);
        checks++; if (pos !== 5'd1) begin errors++; $display("FAIL mid_rst_pos got %0d exp 1", pos); end
        drive(4'b0000, 10);
        checks++; if (valid !== 1'b1 || ascii_out !== 7'h61) begin errors++; $display("FAIL mid_rst_report got valid=%b ascii=%h exp 1 61", valid, ascii_out); end
    endtask

    task automatic test_back_to_back();
        full_fwd();
        drive(4'b0000, 8);
        ack = 1'b1;
        @(negedge sys_clk);
        ack = 1'b0;
        checks++; if (valid !== 1'b1 || ascii_out !== 7'h62 || overrun !== 1'b0) begin errors++; $display("FAIL ack_and_report got valid=%b ascii=%h overrun=%b exp 1 62 0", valid, ascii_out, overrun); end
        ack_pulse();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL final_ack got valid=%b exp 0", valid); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_illegal();
        test_misalign_overrun();
        test_reset_mid_move();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
